// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bit-position counter width; never below one bit so tiny widths still build.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_cell.sv
// 1-bit full adder assembled from two half-adder stages.
module bit_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;
  logic g;

  assign p  = a ^ b;
  assign g  = a & b;
  assign s  = p ^ c;
  assign co = g | (p & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: steps one full-adder cell through WIDTH bit positions, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s;
  logic             c;
  logic             accept;
  logic             last;

  bit_cell u_cell (
    .a  (ra[0]),
    .b  (rb[0]),
    .c  (carry),
    .s  (s),
    .co (c)
  );

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept = in_valid && (state == IDLE);
  assign last   = (state == RUN) && (cnt == CNT_LAST);
  assign rs_nxt = {s, rs[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last RUN cycle captures rs_nxt so the final sum bit lands with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      rs    <= rs_nxt;
      carry <= c;
      if (last) begin
        sum  <= rs_nxt;
        cout <= c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 instance for the main
// scenarios plus a WIDTH=2 instance for the minimum-width build.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic         in_valid2 = 1'b0;
  logic         in_ready2;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic         cin2 = 1'b0;
  logic         out_valid2;
  logic         out_ready2 = 1'b1;
  logic [1:0]   sum2;
  logic         cout2;
  logic         busy2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accept_edge = 0;
  int last_rise = -1;
  bit streaming = 1'b0;
  bit prev_ov = 1'b0;

  logic [W:0] sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one operand set, waits for the accept and records the expected result.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                               input bit keep_valid);
    int n;
    logic [W:0] exp;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic waitResult();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Result monitor: latency, streaming spacing and scoreboard comparison.
  always @(negedge clk) begin
    logic [W:0] exp;
    if (rst_n) begin
      if (in_valid && in_ready) accept_edge = cyc + 1;
      if (out_valid && !prev_ov) begin
        checkOutput("latency", 64'(cyc - accept_edge), 64'(W));
        if (streaming && last_rise >= 0) checkOutput("spacing", 64'(cyc - last_rise), 64'(W + 2));
        last_rise = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 64'd1, 64'd0);
        end else begin
          exp = sb.pop_front();
          checkOutput("sum", 64'(sum), 64'(exp[W-1:0]));
          checkOutput("cout", 64'(cout), 64'(exp[W]));
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int n;
    int acc2;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_in_ready2", 64'(in_ready2), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    waitResult();
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitResult();
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    waitResult();

    // Backpressure with ignored in_valid pulses during RUN and DONE.
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_sum", 64'(sum), 64'h47);
      checkOutput("bp_cout", 64'(cout), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitResult();

    // Asynchronous reset partway through an operation.
    applyStimulus(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_sum", 64'(sum), 64'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    waitResult();
    checkOutput("post_rst_sum", 64'(sum), 64'h02);

    // Back-to-back streaming.
    @(posedge clk);
    #1;
    last_rise = -1;
    streaming = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b0;
    waitResult();
    streaming = 1'b0;

    // Minimum-width instance.
    @(posedge clk);
    #1;
    in_valid2 = 1'b1;
    a2 = 2'd3;
    b2 = 2'd3;
    cin2 = 1'b1;
    @(negedge clk);
    checkOutput("w2_in_ready", 64'(in_ready2), 64'd1);
    acc2 = cyc + 1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w2_out_valid", 64'(out_valid2), 64'd1);
    checkOutput("w2_latency", 64'(cyc - acc2), 64'd2);
    checkOutput("w2_sum", 64'(sum2), 64'd3);
    checkOutput("w2_cout", 64'(cout2), 64'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller that computes an N-bit add on a single 1-bit full-adder cell, one bit per clock, LSB first. It accepts operands over a valid/ready handshake, steps the cell through WIDTH bit positions with a carry register, and returns the registered sum and carry-out over a second valid/ready handshake. It is the area-minimal adder option in the arithmetic datapath, for paths where a WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled only on the accept edge
- b  input  WIDTH  operand B, sampled only on the accept edge
- cin  input  1  carry-in, sampled only on the accept edge
- out_valid  output  1  sum and cout hold a result
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry-out of the result
- busy  output  1  state is not IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - Accept when in_valid && in_ready: load shift registers ra<=a, rb<=b; load carry<=cin; clear bit counter cnt; go to RUN.
- RUN: each cycle the cell computes (s, c) from ra[0], rb[0], carry.
  - s shifts into the MSB of the partial-sum register rs. ra and rb shift right. carry<=c. cnt++.
  - When cnt==WIDTH-1: load sum<=the final rs value, including this cycle's s bit; load cout<=c; go to DONE.
- DONE: out_valid=1. When out_ready is high, go to IDLE.
- cnt width is $clog2(WIDTH). cnt never wraps within an operation.
- in_valid is ignored outside IDLE. a, b and cin changing after the accept edge have no effect.
- sum and cout change only on the RUN->DONE edge. They keep their value after the output handshake until the next result.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry=0, cnt=0, and ra/rb/rs all 0.
- Reset asserted mid-operation: the operation is abandoned immediately, all registers take their reset values, and no result is emitted.

## Timing
- Accept edge T: state goes to RUN. Bit k is processed in the cycle after edge T+k, for k=0..WIDTH-1.
- Edge T+WIDTH: state goes to DONE, and out_valid rises.
  - Latency from the accept edge to out_valid is WIDTH cycles.
- Output handshake edge H (out_valid && out_ready): state goes to IDLE at H, and in_ready rises after H.
  - The next accept can happen no earlier than edge H+1.
- Throughput with in_valid and out_ready tied high: one result every WIDTH+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only, so no combinational path runs from input to output.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum, state_t {IDLE, RUN, DONE};
  - a cnt-width helper function.
- One sub-module, bit_cell: a 1-bit full adder built from two half-adder stages (sum = a^b^c, carry = ab | c(a^b)). It is instantiated once.
- The FSM, shift registers and output registers are in the top module.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → out_valid exactly 8 cycles after the accept edge, with sum=0x96, cout=0.
- Carry chain:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum and cout are stable, in_ready=0. in_valid pulses with new operands during RUN and DONE are ignored, so the result still matches the first operands.
- Reset mid-RUN: assert rst_n=0 asynchronously after bit 3 → immediately IDLE, in_ready=1, out_valid=0, sum=0. After release, a=0x01, b=0x01 gives sum=0x02.
- Streaming: in_valid=out_ready=1 with 1000 random operand sets → every result equals a+b+cin, with results spaced exactly WIDTH+2 cycles apart.
- WIDTH=2 build: a=3, b=3, cin=1 → sum=3, cout=1, latency 2 cycles.
